// File: rtl/mmio_bus_arbiter_if.sv
// Signal bundle between the two MMIO requesters, the arbiter and the shared FPro MMIO bus.
// The master modport is the arbiter's view; slave is the view of the requesters plus the slot array.
interface mmio_bus_arbiter_if #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic              m0_wr;
    logic              m0_lock;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wr_data;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rd_data;

    logic              m1_req;
    logic              m1_wr;
    logic              m1_lock;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wr_data;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rd_data;

    logic              mmio_cs;
    logic              mmio_wr;
    logic              mmio_rd;
    logic [ADDR_W-1:0] mmio_addr;
    logic [DATA_W-1:0] mmio_wr_data;
    logic [DATA_W-1:0] mmio_rd_data;

    logic [1:0]        grant;
    logic              busy;

    modport master (
        input  m0_req, m0_wr, m0_lock, m0_addr, m0_wr_data,
        output m0_ack, m0_rd_data,
        input  m1_req, m1_wr, m1_lock, m1_addr, m1_wr_data,
        output m1_ack, m1_rd_data,
        output mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data,
        input  mmio_rd_data,
        output grant, busy
    );

    modport slave (
        output m0_req, m0_wr, m0_lock, m0_addr, m0_wr_data,
        input  m0_ack, m0_rd_data,
        output m1_req, m1_wr, m1_lock, m1_addr, m1_wr_data,
        input  m1_ack, m1_rd_data,
        input  mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data,
        output mmio_rd_data,
        input  grant, busy
    );
endinterface

// File: rtl/mmio_bus_arbiter.sv
// Round-robin arbiter sharing one FPro MMIO bus between two req/ack masters,
// with an optional ownership lock for read-modify-write sequences.
module mmio_bus_arbiter #(
    parameter int ADDR_W       = 21,
    parameter int DATA_W       = 32,
    parameter int WAIT_CYCLES  = 0,
    parameter int LOCK_TIMEOUT = 16
) (
    input logic                clk,
    input logic                rst,
    mmio_bus_arbiter_if.master bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_ACK    = 2'd2;
    localparam int         LCNT_W    = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    logic [1:0]        state_r;
    logic              last_grant_r;
    logic              lock_valid_r;
    logic              lock_owner_r;
    logic [3:0]        wait_cnt_r;
    logic [LCNT_W-1:0] lock_cnt_r;

    logic              owner_r;
    logic              wr_l_r;
    logic              lock_l_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wr_data_r;

    logic              cs_r;
    logic              bus_wr_r;
    logic              bus_rd_r;
    logic [1:0]        grant_r;
    logic              busy_r;
    logic [1:0]        ack_r;
    logic [DATA_W-1:0] rd_data0_r;
    logic [DATA_W-1:0] rd_data1_r;

    logic [1:0]        req_s;
    logic [1:0]        cand_s;
    logic              win_s;
    logic              sel_wr_s;
    logic              sel_lock_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wr_data_s;

    // Candidate set (restricted to the lock owner while a lock is held) and round-robin winner.
    always_comb begin
        req_s  = {bus.m1_req, bus.m0_req};
        cand_s = 2'b00;
        win_s  = 1'b0;
        if (lock_valid_r) begin
            if (lock_owner_r) begin
                cand_s = {req_s[1], 1'b0};
            end else begin
                cand_s = {1'b0, req_s[0]};
            end
        end else begin
            cand_s = req_s;
        end
        case (cand_s)
            2'b01:   win_s = 1'b0;
            2'b10:   win_s = 1'b1;
            2'b11:   win_s = ~last_grant_r;
            default: win_s = 1'b0;
        endcase
    end

    // Request fields of the winning master, latched on the grant edge.
    always_comb begin
        sel_wr_s      = 1'b0;
        sel_lock_s    = 1'b0;
        sel_addr_s    = '0;
        sel_wr_data_s = '0;
        if (win_s) begin
            sel_wr_s      = bus.m1_wr;
            sel_lock_s    = bus.m1_lock;
            sel_addr_s    = bus.m1_addr;
            sel_wr_data_s = bus.m1_wr_data;
        end else begin
            sel_wr_s      = bus.m0_wr;
            sel_lock_s    = bus.m0_lock;
            sel_addr_s    = bus.m0_addr;
            sel_wr_data_s = bus.m0_wr_data;
        end
    end

    // Arbitration FSM with registered bus strobes, acks and read-data returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b1;
            lock_valid_r <= 1'b0;
            lock_owner_r <= 1'b0;
            wait_cnt_r   <= 4'd0;
            lock_cnt_r   <= '0;
            owner_r      <= 1'b0;
            wr_l_r       <= 1'b0;
            lock_l_r     <= 1'b0;
            addr_r       <= '0;
            wr_data_r    <= '0;
            cs_r         <= 1'b0;
            bus_wr_r     <= 1'b0;
            bus_rd_r     <= 1'b0;
            grant_r      <= 2'b00;
            busy_r       <= 1'b0;
            ack_r        <= 2'b00;
            rd_data0_r   <= '0;
            rd_data1_r   <= '0;
        end else begin
            ack_r <= 2'b00;
            case (state_r)
                ST_IDLE: begin
                    if (cand_s != 2'b00) begin
                        owner_r    <= win_s;
                        wr_l_r     <= sel_wr_s;
                        lock_l_r   <= sel_lock_s;
                        addr_r     <= sel_addr_s;
                        wr_data_r  <= sel_wr_data_s;
                        cs_r       <= 1'b1;
                        bus_wr_r   <= sel_wr_s;
                        bus_rd_r   <= ~sel_wr_s;
                        grant_r    <= win_s ? 2'b10 : 2'b01;
                        busy_r     <= 1'b1;
                        wait_cnt_r <= 4'(WAIT_CYCLES);
                        lock_cnt_r <= '0;
                        state_r    <= ST_ACCESS;
                    end else if (lock_valid_r && !req_s[lock_owner_r]) begin
                        // Idle owner: release the lock once it has been unused long enough.
                        if (lock_cnt_r == LCNT_W'(LOCK_TIMEOUT - 1)) begin
                            lock_valid_r <= 1'b0;
                            lock_cnt_r   <= '0;
                        end else begin
                            lock_cnt_r <= lock_cnt_r + LCNT_W'(1);
                        end
                    end else begin
                        lock_cnt_r <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (wait_cnt_r == 4'd0) begin
                        cs_r     <= 1'b0;
                        bus_wr_r <= 1'b0;
                        bus_rd_r <= 1'b0;
                        if (!wr_l_r) begin
                            if (owner_r) begin
                                rd_data1_r <= bus.mmio_rd_data;
                            end else begin
                                rd_data0_r <= bus.mmio_rd_data;
                            end
                        end else begin
                            rd_data0_r <= rd_data0_r;
                        end
                        ack_r   <= owner_r ? 2'b10 : 2'b01;
                        state_r <= ST_ACK;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end
                end
                ST_ACK: begin
                    grant_r      <= 2'b00;
                    busy_r       <= 1'b0;
                    last_grant_r <= owner_r;
                    lock_valid_r <= lock_l_r;
                    lock_owner_r <= owner_r;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    cs_r     <= 1'b0;
                    bus_wr_r <= 1'b0;
                    bus_rd_r <= 1'b0;
                    grant_r  <= 2'b00;
                    busy_r   <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mmio_cs      = cs_r;
    assign bus.mmio_wr      = bus_wr_r;
    assign bus.mmio_rd      = bus_rd_r;
    assign bus.mmio_addr    = addr_r;
    assign bus.mmio_wr_data = wr_data_r;
    assign bus.m0_ack       = ack_r[0];
    assign bus.m1_ack       = ack_r[1];
    assign bus.m0_rd_data   = rd_data0_r;
    assign bus.m1_rd_data   = rd_data1_r;
    assign bus.grant        = grant_r;
    assign bus.busy         = busy_r;
endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Scoreboard bench for mmio_bus_arbiter: drivers queue expectations when they raise req,
// a negedge monitor pops and compares on every bus access and every ack.
module tb_mmio_bus_arbiter;
    localparam int ADDR_W       = 21;
    localparam int DATA_W       = 32;
    localparam int LOCK_TIMEOUT = 16;

    typedef struct packed {
        logic              wr;
        logic              lock;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } txn_t;

    typedef struct packed {
        logic              rd;
        logic [DATA_W-1:0] data;
    } eack_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    txn_t  pend_q[2][$];
    txn_t  eacc_q[2][$];
    eack_t eack_q[2][$];
    int    gord_q[$];
    logic  act[2];
    int    req_cyc[2];
    int    ack_cyc[2];
    int    cs_rise_cyc[2];

    logic              cs_prev = 1'b0;
    int                cs_len = 0;
    logic              cur_wr;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_data;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mmio_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    mmio_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus3 ();

    mmio_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(0), .LOCK_TIMEOUT(LOCK_TIMEOUT))
        dut (.clk(clk), .rst(rst), .bus(bus.master));
    mmio_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(3), .LOCK_TIMEOUT(LOCK_TIMEOUT))
        dut3 (.clk(clk), .rst(rst), .bus(bus3.master));

    // Slot array model: fixed per-address contents, driven only while a read is selected.
    function automatic logic [DATA_W-1:0] slot_val(input logic [ADDR_W-1:0] a);
        if (a == 21'h00C01) return 32'h12345678;
        return {11'h3C5, a} ^ 32'h0F0F_0000;
    endfunction

    assign bus.mmio_rd_data  = (bus.mmio_cs && bus.mmio_rd) ? slot_val(bus.mmio_addr) : 32'h0;
    assign bus3.mmio_rd_data = 32'h0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic put_req(input int m, input logic r, input txn_t t);
        if (m == 0) begin
            bus.m0_req = r; bus.m0_wr = t.wr; bus.m0_lock = t.lock;
            bus.m0_addr = t.addr; bus.m0_wr_data = t.data;
        end else begin
            bus.m1_req = r; bus.m1_wr = t.wr; bus.m1_lock = t.lock;
            bus.m1_addr = t.addr; bus.m1_wr_data = t.data;
        end
    endtask

    // One driver step per master: drop or replace req in the ack cycle, start queued work.
    task automatic drive(input int m);
        txn_t  t;
        eack_t e;
        logic  ack_now;
        ack_now = (m == 0) ? bus.m0_ack : bus.m1_ack;
        if (act[m] && ack_now) begin
            act[m] = 1'b0;
            put_req(m, 1'b0, '0);
        end
        if (!act[m] && pend_q[m].size() > 0) begin
            t = pend_q[m].pop_front();
            e.rd   = ~t.wr;
            e.data = t.wr ? 32'h0 : slot_val(t.addr);
            eack_q[m].push_back(e);
            eacc_q[m].push_back(t);
            req_cyc[m] = cyc;
            act[m] = 1'b1;
            put_req(m, 1'b1, t);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                drive(0);
                drive(1);
            end
        end
    end

    // Monitor: compares bus accesses and acks against the queued expectations.
    always @(negedge clk) begin
        int    owner;
        txn_t  a;
        eack_t e;
        if (rst) begin
            cs_prev = 1'b0;
        end else begin
            for (int m = 0; m < 2; m++) begin
                if ((m == 0 && bus.m0_ack) || (m == 1 && bus.m1_ack)) begin
                    ack_cyc[m] = cyc;
                    if (eack_q[m].size() == 0) begin
                        chk($sformatf("unexpected_ack_m%0d", m), 32'd1, 32'd0);
                    end else begin
                        e = eack_q[m].pop_front();
                        if (e.rd) chk($sformatf("rd_data_m%0d", m), (m == 0) ? bus.m0_rd_data : bus.m1_rd_data, e.data);
                    end
                end
            end
            if (bus.m0_ack && bus.m1_ack) chk("dual_ack", 32'd1, 32'd0);
            if (bus.mmio_cs && !cs_prev) begin
                owner = (bus.grant == 2'b10) ? 1 : 0;
                chk("grant_onehot", 32'(bus.grant == 2'b01 || bus.grant == 2'b10), 32'd1);
                if (gord_q.size() == 0) chk("unexpected_grant", 32'(owner), 32'hFFFF_FFFF);
                else chk("grant_order", 32'(owner), 32'(gord_q.pop_front()));
                if (eacc_q[owner].size() == 0) begin
                    chk("unexpected_access", 32'd1, 32'd0);
                end else begin
                    a = eacc_q[owner].pop_front();
                    chk("bus_addr", 32'(bus.mmio_addr), 32'(a.addr));
                    chk("bus_wr", 32'(bus.mmio_wr), 32'(a.wr));
                    if (a.wr) chk("bus_wr_data", bus.mmio_wr_data, a.data);
                end
                cs_rise_cyc[owner] = cyc;
                cs_len   = 0;
                cur_wr   = bus.mmio_wr;
                cur_addr = bus.mmio_addr;
                cur_data = bus.mmio_wr_data;
            end
            if (bus.mmio_cs) begin
                cs_len++;
                chk("bus_stable", 32'(bus.mmio_addr == cur_addr && bus.mmio_wr_data == cur_data &&
                                      bus.mmio_wr == cur_wr && bus.mmio_rd == !cur_wr), 32'd1);
            end
            if (!bus.mmio_cs && cs_prev) chk("cs_length", 32'(cs_len), 32'd1);
            cs_prev = bus.mmio_cs;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int m = 0; m < 2; m++) begin
            act[m] = 1'b0;
            put_req(m, 1'b0, '0);
            pend_q[m].delete();
            eacc_q[m].delete();
            eack_q[m].delete();
            ack_cyc[m] = -1;
            cs_rise_cyc[m] = -1;
        end
        gord_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int   n;
        logic done;
        n = 0;
        done = 1'b0;
        while (n < budget && !done) begin
            @(negedge clk);
            #1;
            n++;
            done = (pend_q[0].size() == 0 && pend_q[1].size() == 0 && !act[0] && !act[1] && !bus.busy);
        end
        chk("idle_reached", 32'(done), 32'd1);
        chk("queues_drained", 32'(eack_q[0].size() + eack_q[1].size() + eacc_q[0].size() +
                                  eacc_q[1].size() + gord_q.size()), 32'd0);
    endtask

    function automatic txn_t mk(input logic wr, input logic lock, input logic [ADDR_W-1:0] a,
                                input logic [DATA_W-1:0] d);
        txn_t t;
        t.wr = wr; t.lock = lock; t.addr = a; t.data = d;
        return t;
    endfunction

    initial begin
        int t0, first_cs, ack3, n_cs, a_lock;
        logic stable;
        put_req(0, 1'b0, '0);
        put_req(1, 1'b0, '0);
        act[0] = 1'b0; act[1] = 1'b0;
        bus3.m0_req = 1'b0; bus3.m0_wr = 1'b0; bus3.m0_lock = 1'b0; bus3.m0_addr = '0; bus3.m0_wr_data = '0;
        bus3.m1_req = 1'b0; bus3.m1_wr = 1'b0; bus3.m1_lock = 1'b0; bus3.m1_addr = '0; bus3.m1_wr_data = '0;
        repeat (2) @(negedge clk);
        chk("reset_ctrl", 32'({bus.mmio_cs, bus.mmio_wr, bus.mmio_rd, bus.busy, bus.grant, bus.m0_ack, bus.m1_ack}), 32'd0);
        chk("reset_addr", 32'(bus.mmio_addr), 32'd0);
        chk("reset_wr_data", bus.mmio_wr_data, 32'd0);
        chk("reset_rd_data", bus.m0_rd_data | bus.m1_rd_data, 32'd0);
        chk("reset_w3", 32'({bus3.mmio_cs, bus3.busy, bus3.grant, bus3.m1_ack}), 32'd0);
        do_reset();

        // 1: single m0 read, zero wait states
        pend_q[0].push_back(mk(1'b0, 1'b0, 21'h00C01, 32'h0));
        gord_q.push_back(0);
        wait_idle(20);
        chk("t1_cs_latency", 32'(cs_rise_cyc[0] - req_cyc[0]), 32'd1);
        chk("t1_ack_latency", 32'(ack_cyc[0] - req_cyc[0]), 32'd2);
        chk("t1_m0_rd_data", bus.m0_rd_data, 32'h12345678);
        chk("t1_no_m1_ack", 32'(ack_cyc[1]), 32'hFFFF_FFFF);

        // 2: simultaneous requests after reset, m0 wins the first tie
        do_reset();
        pend_q[0].push_back(mk(1'b1, 1'b0, 21'h00100, 32'h000000A5));
        pend_q[1].push_back(mk(1'b0, 1'b0, 21'h00200, 32'h0));
        gord_q.push_back(0); gord_q.push_back(1);
        wait_idle(30);
        chk("t2_ack_spacing", 32'(ack_cyc[1] - ack_cyc[0]), 32'd3);

        // 3: continuous requests from both masters alternate
        pend_q[0].push_back(mk(1'b0, 1'b0, 21'h01000, 32'h0));
        pend_q[0].push_back(mk(1'b1, 1'b0, 21'h01004, 32'hCAFE0001));
        pend_q[0].push_back(mk(1'b0, 1'b0, 21'h01008, 32'h0));
        pend_q[1].push_back(mk(1'b0, 1'b0, 21'h02000, 32'h0));
        pend_q[1].push_back(mk(1'b0, 1'b0, 21'h02004, 32'h0));
        pend_q[1].push_back(mk(1'b1, 1'b0, 21'h02008, 32'hCAFE0002));
        for (int i = 0; i < 3; i++) begin
            gord_q.push_back(0);
            gord_q.push_back(1);
        end
        wait_idle(60);
        chk("t3_m0_rd_hold", bus.m0_rd_data, slot_val(21'h01008));
        chk("t3_m1_rd_hold", bus.m1_rd_data, slot_val(21'h02004));

        // 4: three wait states on the second instance
        do_reset();
        @(posedge clk);
        #1;
        t0 = cyc;
        bus3.m1_wr = 1'b1; bus3.m1_addr = 21'h0ABCD; bus3.m1_wr_data = 32'hDEADBEEF; bus3.m1_req = 1'b1;
        n_cs = 0; first_cs = -1; ack3 = -1; stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus3.mmio_cs) begin
                if (first_cs < 0) first_cs = cyc;
                n_cs++;
                if (!bus3.mmio_wr || bus3.mmio_rd || bus3.mmio_addr != 21'h0ABCD ||
                    bus3.mmio_wr_data != 32'hDEADBEEF || bus3.grant != 2'b10) stable = 1'b0;
            end
            if (bus3.m1_ack && ack3 < 0) begin
                ack3 = cyc;
                bus3.m1_req = 1'b0;
            end
        end
        chk("t4_cs_cycles", 32'(n_cs), 32'd4);
        chk("t4_cs_start", 32'(first_cs - t0), 32'd1);
        chk("t4_ack_latency", 32'(ack3 - t0), 32'd5);
        chk("t4_bus_stable", 32'(stable), 32'd1);

        // 5a: locked read keeps m0 ahead of a waiting m1
        do_reset();
        pend_q[0].push_back(mk(1'b0, 1'b1, 21'h00300, 32'h0));
        pend_q[0].push_back(mk(1'b1, 1'b0, 21'h00304, 32'h000055AA));
        pend_q[1].push_back(mk(1'b0, 1'b0, 21'h00400, 32'h0));
        gord_q.push_back(0); gord_q.push_back(0); gord_q.push_back(1);
        wait_idle(40);

        // 5b: lock released by timeout; grant decided LOCK_TIMEOUT+1 cycles after the ack, bus seen one later
        do_reset();
        pend_q[0].push_back(mk(1'b0, 1'b1, 21'h00500, 32'h0));
        gord_q.push_back(0); gord_q.push_back(1);
        for (int i = 0; i < 20 && ack_cyc[0] < 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("t5_locked_ack_seen", 32'(ack_cyc[0] >= 0), 32'd1);
        a_lock = ack_cyc[0];
        pend_q[1].push_back(mk(1'b0, 1'b0, 21'h00540, 32'h0));
        wait_idle(60);
        chk("t5_timeout_grant", 32'(cs_rise_cyc[1] - a_lock), 32'(LOCK_TIMEOUT + 2));

        // 6: reset during an m0 access aborts it silently
        do_reset();
        pend_q[0].push_back(mk(1'b0, 1'b0, 21'h00600, 32'h0));
        gord_q.push_back(0);
        for (int i = 0; i < 10 && !bus.mmio_cs; i++) begin
            @(negedge clk);
            #1;
        end
        chk("t6_access_seen", 32'(bus.mmio_cs), 32'd1);
        rst = 1'b1;
        act[0] = 1'b0;
        put_req(0, 1'b0, '0);
        eack_q[0].delete();
        @(negedge clk);
        #1;
        chk("t6_abort_ctrl", 32'({bus.mmio_cs, bus.mmio_rd, bus.busy, bus.grant, bus.m0_ack}), 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("t6_no_m0_ack", 32'(ack_cyc[0]), 32'hFFFF_FFFF);
        pend_q[1].push_back(mk(1'b0, 1'b0, 21'h00700, 32'h0));
        gord_q.push_back(1);
        wait_idle(20);
        chk("t6_m1_done", bus.m1_rd_data, slot_val(21'h00700));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mmio_bus_arbiter.md
Name: mmio_bus_arbiter

Overview:
Shares the single FPro MMIO bus, which feeds the MMIO controller and its slot array, between two requesters: master 0 (CPU bridge) and master 1 (debug/loader or DMA engine).
- Each master runs an independent req/ack handshake. The arbiter grants round-robin, latches the winning request, drives one bus access with optional wait cycles, returns read data and pulses ack.
- An optional lock holds ownership across back-to-back transactions (read-modify-write of slot registers).

Parameters:
ADDR_W, 21, MMIO address width (matches mmio_addr)
DATA_W, 32, MMIO data width
WAIT_CYCLES, 0, extra cycles mmio_cs stays asserted beyond the first access cycle (0..15)
LOCK_TIMEOUT, 16, idle cycles after which an unused lock is released (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
m0_req  in  1  master 0 transaction request, held until m0_ack
m0_wr  in  1  1=write, 0=read
m0_lock  in  1  keep ownership after this transaction
m0_addr  in  ADDR_W  target MMIO address
m0_wr_data  in  DATA_W  write data
m0_ack  out  1  one-cycle completion pulse
m0_rd_data  out  DATA_W  read data, valid while m0_ack=1
m1_req, m1_wr, m1_lock, m1_addr, m1_wr_data, m1_ack, m1_rd_data  same as master 0, for master 1
mmio_cs  out  1  bus chip select
mmio_wr  out  1  bus write strobe
mmio_rd  out  1  bus read strobe
mmio_addr  out  ADDR_W  bus address
mmio_wr_data  out  DATA_W  bus write data
mmio_rd_data  in  DATA_W  bus read data (combinational from the selected slot)
grant  out  2  one-hot current owner, nonzero only in ACCESS/ACK
busy  out  1  1 whenever state != IDLE

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - All outputs are 0. This includes mmio_addr, mmio_wr_data and both mN_rd_data.
  - State = IDLE, last_grant = 1 (master 0 wins first tie), lock_valid = 0, wait counter = 0, lock-timeout counter = 0.
- Reset mid-transaction: abort at the next edge and return to IDLE. No ack is issued and cs/rd/wr drop in the same cycle.

State machine: IDLE -> ACCESS -> ACK -> IDLE.
- IDLE:
  - cs/rd/wr = 0.
  - Form the candidate set from mN_req. If lock_valid, only the lock owner is a candidate.
  - If both are candidates, grant the master that is not last_grant.
  - On grant: latch wr, lock, addr and wr_data into internal registers, set grant, load the wait counter with WAIT_CYCLES, and go to ACCESS.
- ACCESS:
  - mmio_cs = 1. mmio_wr = latched wr; mmio_rd = !latched wr.
  - mmio_addr and mmio_wr_data come from the latched registers. They stay stable for the whole access and hold their last value afterwards.
  - Lasts WAIT_CYCLES+1 cycles. On the final cycle, register mmio_rd_data into the owner's mN_rd_data (reads only), then go to ACK.
- ACK:
  - Pulse the owner's mN_ack for one cycle. mN_rd_data is valid in this cycle and holds until that master's next read.
  - Update last_grant = owner. Set lock_valid = latched lock and lock_owner = owner. Go to IDLE.
- Latency: req first sampled high at the end of cycle t.
  - mmio_cs is high in cycles t+1 .. t+1+WAIT_CYCLES.
  - mN_ack is high in cycle t+2+WAIT_CYCLES.
  - Minimum spacing between grants is 3+WAIT_CYCLES cycles.
- Handshake rules:
  - A master holds req and its fields until ack. Changes to fields after the grant edge have no effect.
  - req still high in the cycle after ack counts as a new transaction.
  - The non-granted master's req stays pending with no timeout and no ack.
- Lock:
  - While lock_valid, the other master's requests are blocked.
  - Lock is released when the owner completes a transaction with lock=0.
  - Lock is also released when the owner has req=0 for LOCK_TIMEOUT consecutive IDLE cycles. The counter is cleared by each grant.
  - If the release and the other master's req fall in the same IDLE cycle, the release takes effect first and the grant is made in the next cycle.
- Simultaneous requests: at most one grant per IDLE cycle, and the grant is never given to both masters.
- Fairness: with both masters requesting continuously and lock=0, grants alternate.
- Read data: the master whose read was not serviced keeps its old mN_rd_data.

Test Plan:
1. Reset, then m0 reads 0x00C01 with WAIT_CYCLES=0 and mmio_rd_data=0x12345678. mmio_cs/rd are high exactly one cycle with mmio_addr=0x00C01. m0_ack is high 2 cycles after req with m0_rd_data=0x12345678. m1_ack stays 0.
2. Both masters request at the same edge after reset: m0 write 0xA5 to addr 0x100, m1 read 0x200. m0 is served first, then m1. grant sequence is 01, then 10. The acks are 3 cycles apart.
3. Both masters hold req continuously for 6 transactions. Grants alternate 0,1,0,1,0,1 and no ack is ever adjacent to ack of the same master without an intervening grant to the other.
4. WAIT_CYCLES=3: m1 writes 0xDEADBEEF. mmio_cs/wr are high 4 consecutive cycles, addr and wr_data are constant, and m1_ack is high 5 cycles after req.
5. m0 issues a read with lock=1 while m1 requests. m0's follow-up write (lock=0) is granted before m1, and m1 is granted after that. Repeat with m0 idle after the locked read: m1 is granted LOCK_TIMEOUT(16)+1 cycles after the locked ack.
6. Assert rst during ACCESS of an m0 read. cs/rd go to 0 at the next edge, no m0_ack ever pulses, busy=0, and a subsequent m1 request completes normally.
